hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/pipe_pkg.sv | 84 ++++++++
 rtl/hazard_scoreboard.sv | 44 ++++
 rtl/hazard_ctrl.sv | 87 ++++++++
 tb/tb_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field slices,
// hazard FSM state encodings and the ID-stage decode helper.
package pipe_pkg;

    localparam logic [5:0] OP_LD    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b100010;
    localparam logic [5:0] OP_BNE   = 6'b100011;
    localparam logic [5:0] OP_RTYPE = 6'b101010;
    localparam logic [5:0] OP_NOP   = 6'b111100;

    // Field positions in the big-endian [0:31] instruction word
    localparam int OPC_MSB = 0;
    localparam int OPC_LSB = 5;
    localparam int RD_MSB  = 6;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 15;
    localparam int RB_MSB  = 16;
    localparam int RB_LSB  = 20;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    typedef struct packed {
        logic [4:0] dest;
        logic       regwrite;
        logic       memread;
    } sb_entry_t;

    typedef struct packed {
        logic [4:0] src_a;
        logic [4:0] src_b;
        logic       use_a;
        logic       use_b;
        logic       is_branch;
        sb_entry_t  wr;
    } id_dec_t;

    // Source/destination usage of the instruction sitting in ID
    function automatic id_dec_t decode_id(input logic [0:31] instr);
        id_dec_t    d;
        logic [5:0] op;
        logic [4:0] rd;
        logic [4:0] ra;
        logic [4:0] rb;
        op = instr[OPC_MSB:OPC_LSB];
        rd = instr[RD_MSB:RD_LSB];
        ra = instr[RA_MSB:RA_LSB];
        rb = instr[RB_MSB:RB_LSB];
        d  = '0;
        case (op)
            OP_RTYPE: begin
                d.src_a = ra;
                d.use_a = 1'b1;
                d.src_b = rb;
                d.use_b = 1'b1;
                d.wr    = '{dest: rd, regwrite: 1'b1, memread: 1'b0};
            end
            OP_SW: begin
                d.src_a = rd;
                d.use_a = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                d.src_a     = rd;
                d.use_a     = 1'b1;
                d.src_b     = ra;
                d.use_b     = 1'b1;
                d.is_branch = 1'b1;
            end
            OP_LD: begin
                d.wr = '{dest: rd, regwrite: 1'b1, memread: 1'b1};
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry (EX, MEM) destination scoreboard and the ID-stage hazard compare.
// Register 0 is deliberately not special-cased.
module hazard_scoreboard
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  id_dec_t id_dec,
    input  logic    insert_zero,
    output logic    hazard
);

    sb_entry_t ex_q;
    sb_entry_t mem_q;
    logic      load_use;
    logic      br_haz;

    function automatic logic hit(input logic [4:0] src, input logic use_src, input sb_entry_t e);
        return use_src && e.regwrite && (e.dest == src);
    endfunction

    // Shift the scoreboard each cycle; a bubble or flush leaves a zero entry in EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= insert_zero ? '0 : id_dec.wr;
        end
    end

    // Load-use needs only EX; branches resolve in ID so also wait on a load in MEM
    always_comb begin
        load_use = !id_dec.is_branch && ex_q.memread &&
                   (hit(id_dec.src_a, id_dec.use_a, ex_q) || hit(id_dec.src_b, id_dec.use_b, ex_q));
        br_haz   = id_dec.is_branch &&
                   (hit(id_dec.src_a, id_dec.use_a, ex_q) || hit(id_dec.src_b, id_dec.use_b, ex_q) ||
                    (mem_q.memread &&
                     (hit(id_dec.src_a, id_dec.use_a, mem_q) || hit(id_dec.src_b, id_dec.use_b, mem_q))));
        hazard   = load_use || br_haz;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble generation, ID-stage branch
// resolution, wrong-path flush sequencing and a saturating stall counter.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:31] id_instr,
    input  logic [0:1]  id_br,
    input  logic        id_cmp_eq,
    output logic        pc_stall,
    output logic        if2id_stall,
    output logic        id2ex_bubble,
    output logic        if2id_flush,
    output logic        br_taken,
    output logic [0:1]  hz_state,
    output logic [0:15] stall_cnt
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    id_dec_t    dec;
    logic       in_flush;
    logic       active;
    logic       sb_hazard;
    logic       hazard;
    logic       br_cond;
    logic       unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    assign unused_bits = ^id_instr[21:31];

    // The wrong-path instruction in ID during FLUSH contributes nothing
    always_comb begin
        in_flush = (state == ST_FLUSH);
        active   = (state == ST_RUN) || (state == ST_STALL);
        dec      = in_flush ? '0 : decode_id(id_instr);
    end

    hazard_scoreboard u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_dec      (dec),
        .insert_zero (id2ex_bubble | in_flush),
        .hazard      (sb_hazard)
    );

    // Stall controls and branch decision, all combinational from live ID inputs
    always_comb begin
        hazard       = active && sb_hazard;
        pc_stall     = hazard;
        if2id_stall  = hazard;
        id2ex_bubble = hazard;
        br_cond      = ((id_br == BR_EQ) && id_cmp_eq) || ((id_br == BR_NE) && !id_cmp_eq);
        br_taken     = br_cond && active && !hazard;
        if2id_flush  = in_flush;
        hz_state     = state;
    end

    // Next-state: stall wins over a branch; FLUSH always lasts one cycle
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN, ST_STALL: begin
                if (hazard)        state_nxt = ST_STALL;
                else if (br_taken) state_nxt = ST_FLUSH;
                else               state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // State register and saturating stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            stall_cnt <= sat_inc(stall_cnt, pc_stall);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// instruction streams checked against a distance-based reference model.
module tb_hazard_ctrl;

    localparam logic [5:0] T_LD    = 6'b100000;
    localparam logic [5:0] T_SW    = 6'b100001;
    localparam logic [5:0] T_BEQ   = 6'b100010;
    localparam logic [5:0] T_BNE   = 6'b100011;
    localparam logic [5:0] T_RTYPE = 6'b101010;
    localparam logic [5:0] T_NOP   = 6'b111100;
    localparam logic [5:0] T_OTHER = 6'b000111;

    logic        clk;
    logic        rst_n;
    logic [0:31] id_instr;
    logic [0:1]  id_br;
    logic        id_cmp_eq;
    logic        pc_stall;
    logic        if2id_stall;
    logic        id2ex_bubble;
    logic        if2id_flush;
    logic        br_taken;
    logic [0:1]  hz_state;
    logic [0:15] stall_cnt;
    logic [6:0]  ex_obs;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_instr     (id_instr),
        .id_br        (id_br),
        .id_cmp_eq    (id_cmp_eq),
        .pc_stall     (pc_stall),
        .if2id_stall  (if2id_stall),
        .id2ex_bubble (id2ex_bubble),
        .if2id_flush  (if2id_flush),
        .br_taken     (br_taken),
        .hz_state     (hz_state),
        .stall_cnt    (stall_cnt)
    );

    assign ex_obs = dut.u_sb.ex_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: issued instructions tagged by how far ahead they are
    typedef struct {
        int dest;
        bit wr;
        bit ld;
    } ent_t;

    localparam ent_t EMPTY = '{dest: 0, wr: 1'b0, ld: 1'b0};

    ent_t m_ex, m_mem, m_dec;
    bit   m_flush, m_stalled;
    int   m_cnt;
    bit   e_haz, e_taken;
    logic obs_stall, obs_taken, obs_flush;
    logic [1:0] obs_state;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [0:31] mk(input logic [5:0] op, input int rd, input int ra, input int rb);
        logic [0:31] r;
        r = '0;
        r[0:5]   = op;
        r[6:10]  = 5'(rd);
        r[11:15] = 5'(ra);
        r[16:20] = 5'(rb);
        return r;
    endfunction

    function automatic logic [31:0] ent_bits(input ent_t e);
        logic [4:0] d5;
        d5 = 5'(e.dest);
        if (!e.wr) return 32'd0;
        return {25'd0, d5, e.wr, e.ld};
    endfunction

    // Minimum issue distance between producer and consumer with ID-stage branch compare
    function automatic int need_gap(input bit consumer_br, input bit producer_ld);
        if (consumer_br) return producer_ld ? 3 : 2;
        return producer_ld ? 2 : 1;
    endfunction

    function automatic void mdec(input logic [0:31] ins, output int sa, output int sb,
                                 output bit isbr, output ent_t e);
        logic [5:0] op;
        int rd, ra, rb;
        op = ins[0:5];
        rd = int'(ins[6:10]);
        ra = int'(ins[11:15]);
        rb = int'(ins[16:20]);
        sa = -1; sb = -1; isbr = 1'b0; e = EMPTY;
        if (op == T_RTYPE) begin
            sa = ra; sb = rb; e = '{dest: rd, wr: 1'b1, ld: 1'b0};
        end else if (op == T_SW) begin
            sa = rd;
        end else if (op == T_BEQ || op == T_BNE) begin
            sa = rd; sb = ra; isbr = 1'b1;
        end else if (op == T_LD) begin
            e = '{dest: rd, wr: 1'b1, ld: 1'b1};
        end
    endfunction

    task automatic model_eval();
        int sa, sb;
        bit isbr;
        ent_t e;
        ent_t prod[2];
        if (m_flush) begin
            sa = -1; sb = -1; isbr = 1'b0; e = EMPTY;
        end else begin
            mdec(id_instr, sa, sb, isbr, e);
        end
        prod[0] = m_ex;
        prod[1] = m_mem;
        e_haz = 1'b0;
        for (int d = 1; d <= 2; d++) begin
            if (prod[d-1].wr && ((sa >= 0 && sa == prod[d-1].dest) || (sb >= 0 && sb == prod[d-1].dest))
                && d < need_gap(isbr, prod[d-1].ld))
                e_haz = 1'b1;
        end
        e_taken = !m_flush && !e_haz &&
                  ((id_br == 2'b01 && id_cmp_eq) || (id_br == 2'b10 && !id_cmp_eq));
        m_dec = e;
    endtask

    task automatic model_advance();
        m_mem     = m_ex;
        m_ex      = (e_haz || m_flush) ? EMPTY : m_dec;
        m_flush   = e_taken;
        m_stalled = e_haz;
        if (e_haz && m_cnt < 65535) m_cnt++;
    endtask

    task automatic model_reset();
        m_ex = EMPTY; m_mem = EMPTY; m_flush = 1'b0; m_stalled = 1'b0; m_cnt = 0;
    endtask

    function automatic logic [31:0] exp_state();
        if (m_flush) return 32'd2;
        if (m_stalled) return 32'd1;
        return 32'd0;
    endfunction

    task automatic check_outputs(input string pfx);
        model_eval();
        check_eq({pfx, "ex_entry"},     32'(ex_obs),       ent_bits(m_ex));
        check_eq({pfx, "pc_stall"},     32'(pc_stall),     32'(e_haz));
        check_eq({pfx, "if2id_stall"},  32'(if2id_stall),  32'(e_haz));
        check_eq({pfx, "id2ex_bubble"}, 32'(id2ex_bubble), 32'(e_haz));
        check_eq({pfx, "if2id_flush"},  32'(if2id_flush),  32'(m_flush));
        check_eq({pfx, "br_taken"},     32'(br_taken),     32'(e_taken));
        check_eq({pfx, "hz_state"},     32'(hz_state),     exp_state());
        check_eq({pfx, "stall_cnt"},    32'(stall_cnt),    32'(m_cnt));
    endtask

    // One ID cycle: drive at the negedge, check mid-cycle, advance at the posedge
    task automatic step(input logic [0:31] ins, input logic [1:0] br, input logic eq);
        id_instr = ins; id_br = br; id_cmp_eq = eq;
        #1;
        check_outputs("");
        obs_stall = pc_stall;
        obs_taken = br_taken;
        obs_flush = if2id_flush;
        obs_state = hz_state;
        model_advance();
        @(negedge clk);
    endtask

    // Assert reset with whatever ID inputs are currently applied
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_");
        check_eq("rst_state_const", 32'(hz_state), 32'd0);
        check_eq("rst_cnt_const", 32'(stall_cnt), 32'd0);
        check_eq("rst_flush_const", 32'(if2id_flush), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [0:31] nop_i, ld5, add7, add3, beq34, ld3, bne12, add9, ld_r5b;

    initial begin
        nop_i  = mk(T_NOP, 0, 0, 0);
        ld5    = mk(T_LD, 5, 0, 0);
        add7   = mk(T_RTYPE, 7, 5, 2);
        add3   = mk(T_RTYPE, 3, 1, 2);
        beq34  = mk(T_BEQ, 3, 4, 0);
        ld3    = mk(T_LD, 3, 0, 0);
        bne12  = mk(T_BNE, 1, 2, 0);
        add9   = mk(T_RTYPE, 9, 1, 2);
        ld_r5b = mk(T_LD, 5, 1, 1);

        rst_n = 1'b0; id_instr = nop_i; id_br = 2'b00; id_cmp_eq = 1'b0;
        do_reset();

        // load-use: one stall cycle
        step(ld5, 2'b00, 1'b0);
        step(add7, 2'b00, 1'b0);
        check_eq("lu_stall1", 32'(obs_stall), 32'd1);
        step(add7, 2'b00, 1'b0);
        check_eq("lu_stall_end", 32'(obs_stall), 32'd0);
        check_eq("lu_cnt", 32'(stall_cnt), 32'd1);

        // ALU then branch: one stall, then branch follows comparator
        id_instr = nop_i; do_reset();
        step(add3, 2'b00, 1'b0);
        step(beq34, 2'b01, 1'b1);
        check_eq("alu_br_stall", 32'(obs_stall), 32'd1);
        step(beq34, 2'b01, 1'b1);
        check_eq("alu_br_nostall", 32'(obs_stall), 32'd0);
        check_eq("alu_br_taken", 32'(obs_taken), 32'd1);
        step(add9, 2'b00, 1'b0);
        check_eq("alu_br_flush", 32'(obs_flush), 32'd1);

        // ld then branch: two stalls, state STALL after each
        id_instr = nop_i; do_reset();
        step(ld3, 2'b00, 1'b0);
        step(beq34, 2'b01, 1'b0);
        check_eq("ld_br_stall1", 32'(obs_stall), 32'd1);
        check_eq("ld_br_state1", 32'(hz_state), 32'd1);
        step(beq34, 2'b01, 1'b0);
        check_eq("ld_br_stall2", 32'(obs_stall), 32'd1);
        check_eq("ld_br_state2", 32'(hz_state), 32'd1);
        step(beq34, 2'b01, 1'b0);
        check_eq("ld_br_release", 32'(obs_stall), 32'd0);
        check_eq("ld_br_not_taken", 32'(obs_taken), 32'd0);
        check_eq("ld_br_cnt", 32'(stall_cnt), 32'd2);

        // bne taken, wrong-path add r9 squashed into a zero EX entry
        id_instr = nop_i; do_reset();
        step(nop_i, 2'b00, 1'b0);
        step(bne12, 2'b10, 1'b0);
        check_eq("bne_taken", 32'(obs_taken), 32'd1);
        step(add9, 2'b00, 1'b0);
        check_eq("bne_flush", 32'(obs_flush), 32'd1);
        check_eq("bne_flush_state", 32'(obs_state), 32'd2);
        check_eq("bne_ex_zero", 32'(ex_obs), 32'd0);
        step(nop_i, 2'b00, 1'b0);
        check_eq("bne_flush_once", 32'(obs_flush), 32'd0);

        // reset during the second cycle of a ld->beq stall
        id_instr = nop_i; do_reset();
        step(ld3, 2'b00, 1'b0);
        step(beq34, 2'b01, 1'b0);
        id_instr = beq34; id_br = 2'b01; id_cmp_eq = 1'b0;
        #1;
        check_eq("midstall_active", 32'(pc_stall), 32'd1);
        do_reset();
        step(beq34, 2'b01, 1'b0);
        check_eq("post_rst_nostall", 32'(obs_stall), 32'd0);

        // counter saturation
        id_instr = nop_i; do_reset();
        force dut.stall_cnt = 16'hFFFE;
        m_cnt = 65534;
        step(nop_i, 2'b00, 1'b0);
        release dut.stall_cnt;
        step(ld3, 2'b00, 1'b0);
        step(beq34, 2'b01, 1'b0);
        step(beq34, 2'b01, 1'b0);
        step(beq34, 2'b01, 1'b0);
        check_eq("sat_mid", 32'(stall_cnt), 32'hFFFF);
        step(ld_r5b, 2'b00, 1'b0);
        step(add7, 2'b00, 1'b0);
        step(add7, 2'b00, 1'b0);
        check_eq("sat_hold", 32'(stall_cnt), 32'hFFFF);

        // randomized streams over a small register pool
        id_instr = nop_i; do_reset();
        begin
            logic [0:31] ins;
            logic [1:0]  br;
            logic [5:0]  op;
            bit          hold;
            ins = nop_i; br = 2'b00; hold = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if (!hold) begin
                    case ($urandom_range(0, 6))
                        0: op = T_RTYPE;
                        1: op = T_LD;
                        2: op = T_SW;
                        3: op = T_BEQ;
                        4: op = T_BNE;
                        5: op = T_NOP;
                        default: op = T_OTHER;
                    endcase
                    ins = mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                             int'($urandom_range(0, 3)));
                    br = (op == T_BEQ) ? 2'b01 : (op == T_BNE) ? 2'b10 : 2'b00;
                    if ($urandom_range(0, 7) == 0) br = 2'($urandom_range(0, 3));
                end
                step(ins, br, 1'($urandom_range(0, 1)));
                hold = e_haz;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
